// File: rtl/instr_mem_loader.sv
// Boot loader: parses a framed program image from a byte stream, writes
// little-endian 32-bit words into instruction memory, and gates core reset.
module instr_mem_loader #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_rx_ready,
    output logic                    o_we,
    output logic [P_ADDR_WIDTH-1:0] o_waddr,
    output logic [P_DATA_WIDTH-1:0] o_wdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic                    o_cpu_rst
);

    localparam int          LP_WI    = P_ADDR_WIDTH - 2;
    localparam int unsigned LP_WORDS = 2 ** LP_WI;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              count_lo_q, count_lo_d;
    logic [LP_WI-1:0]        last_idx_q, last_idx_d;
    logic [LP_WI-1:0]        word_idx_q, word_idx_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              xor_q, xor_d;
    logic [7:0]              lane_q [0:2];
    logic [7:0]              lane_d [0:2];
    logic                    we_q, we_d;
    logic [P_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic        rx_ready;
    logic        accept;
    logic [15:0] count_w;

    assign rx_ready = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign accept   = i_rx_valid & rx_ready;
    assign count_w  = {i_rx_data, count_lo_q};

    // Lower three bytes of a word are parked per lane; the 4th byte goes
    // straight into the write word so no extra cycle is spent assembling.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_d[gi] = (accept && (state_q == ST_DATA) && (byte_idx_q == 2'(gi)))
                                ? i_rx_data : lane_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        count_lo_d = count_lo_q;
        last_idx_d = last_idx_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d    = ST_HDR_LO;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    xor_d      = '0;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    count_lo_d = i_rx_data;
                    xor_d      = xor_q ^ i_rx_data;
                    state_d    = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    xor_d      = xor_q ^ i_rx_data;
                    last_idx_d = LP_WI'(count_w - 16'd1);
                    if (32'(count_w) > LP_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (count_w == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    xor_d      = xor_q ^ i_rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdata_d    = P_DATA_WIDTH'({i_rx_data, lane_q[2], lane_q[1], lane_q[0]});
                        waddr_d    = {word_idx_q, 2'b00};
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_q == last_idx_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    state_d = (i_rx_data == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            count_lo_q <= '0;
            last_idx_q <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_lo_q <= count_lo_d;
            last_idx_q <= last_idx_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            for (int i = 0; i < 3; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    // Session status is a pure function of the state, so a new i_start
    // clears done/error simply by leaving DONE/ERROR.
    assign o_rx_ready = rx_ready;
    assign o_busy     = rx_ready;
    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_done     = (state_q == ST_DONE);
    assign o_error    = (state_q == ST_ERROR);
    assign o_cpu_rst  = (state_q != ST_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: frames are parsed by a simple
// reference model and the captured memory writes and status are compared.
module tb_instr_mem_loader;

    typedef logic [7:0] byte_q_t [$];

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_rx_ready;
    logic       o_we;
    logic [9:0] o_waddr;
    logic [31:0] o_wdata;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic       o_cpu_rst;

    instr_mem_loader #(
        .P_DATA_WIDTH(32),
        .P_ADDR_WIDTH(10)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_we       (o_we),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_error    (o_error),
        .o_cpu_rst  (o_cpu_rst)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    logic [9:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          acc_cyc_q [$];

    logic [9:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic        exp_done;
    logic        exp_error;

    always @(negedge i_clk) begin
        if (o_we === 1'b1) begin
            wr_addr_q.push_back(o_waddr);
            wr_data_q.push_back(o_wdata);
            wr_cyc_q.push_back(cyc);
            $display("[TB] write addr=%h data=%h rx_ready=%b", o_waddr, o_wdata, o_rx_ready);
            tests++;
            if (o_rx_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL we_ready: o_rx_ready=%b required 1", o_rx_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: interpret the frame directly from its byte layout.
    task automatic model(input byte_q_t b);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'({b[1], b[0]});
        if (n > 256) begin
            exp_done  = 1'b0;
            exp_error = 1'b1;
            return;
        end
        x = b[0] ^ b[1];
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = w | (32'(b[2 + 4*i + k]) << (8*k));
                x = x ^ b[2 + 4*i + k];
            end
            exp_addr.push_back(10'(i * 4));
            exp_data.push_back(w);
        end
        exp_done  = (b[2 + 4*n] == x);
        exp_error = !exp_done;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic do_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        bit r;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge i_clk);
                i_rx_valid = 1'b0;
                i_rx_data  = 8'($urandom);
                i_start    = ($urandom_range(0, 3) == 0);
                @(posedge i_clk);
            end
        end
        @(negedge i_clk);
        i_start    = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (c > 0) @(negedge i_clk);
            r = o_rx_ready;
            @(posedge i_clk);
            ok = r;
        end
        #1;
        acc_cyc_q.push_back(cyc);
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: byte %h not accepted within 100 cycles", b);
        end
    endtask

    task automatic run_frame(input byte_q_t b, input bit gaps);
        clear_logs();
        do_start();
        foreach (b[i]) send_byte(b[i], gaps);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data = 8'h55;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        tests++;
        if ({o_cpu_rst, o_rx_ready, o_we, o_busy, o_done, o_error} !== 6'b100000) begin
            fails++;
            $display("[TB] FAIL reset_flags: cpu_rst,ready,we,busy,done,error=%b required 100000",
                     {o_cpu_rst, o_rx_ready, o_we, o_busy, o_done, o_error});
        end
        tests++;
        if (o_waddr !== 10'h0 || o_wdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_bus: waddr=%h wdata=%h required 0/0", o_waddr, o_wdata);
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        tests++;
        if (o_busy !== 1'b0 || o_rx_ready !== 1'b0 || wr_addr_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL reset_no_accept: busy=%b ready=%b writes=%0d required 0/0/0",
                     o_busy, o_rx_ready, wr_addr_q.size());
        end
        $display("[TB] reset test done");
    endtask

    task automatic test_good_load();
        byte_q_t b;
        b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        model(b);
        run_frame(b, 1'b0);
        tests++;
        if (wr_addr_q.size() != 2) begin
            fails++;
            $display("[TB] FAIL good_count: writes=%0d required 2", wr_addr_q.size());
        end else begin
            tests++;
            if (wr_addr_q[0] !== 10'h000 || wr_data_q[0] !== 32'h00500093) begin
                fails++;
                $display("[TB] FAIL good_w0: %h/%h required 000/00500093", wr_addr_q[0], wr_data_q[0]);
            end
            tests++;
            if (wr_addr_q[1] !== 10'h004 || wr_data_q[1] !== 32'h00A00113) begin
                fails++;
                $display("[TB] FAIL good_w1: %h/%h required 004/00a00113", wr_addr_q[1], wr_data_q[1]);
            end
            for (int j = 0; j < 2; j++) begin
                tests++;
                if (wr_cyc_q[j] != acc_cyc_q[2 + 4*j + 3]) begin
                    fails++;
                    $display("[TB] FAIL good_latency%0d: we cycle=%0d required %0d",
                             j, wr_cyc_q[j], acc_cyc_q[2 + 4*j + 3]);
                end
            end
        end
        tests++;
        if ({o_done, o_error, o_cpu_rst, o_busy} !== {exp_done, exp_error, 2'b00}) begin
            fails++;
            $display("[TB] FAIL good_status: done,error,cpu_rst,busy=%b required %b",
                     {o_done, o_error, o_cpu_rst, o_busy}, {exp_done, exp_error, 2'b00});
        end
        $display("[TB] good load done");
    endtask

    task automatic test_bad_checksum();
        byte_q_t b;
        b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h74};
        model(b);
        run_frame(b, 1'b0);
        tests++;
        if (wr_addr_q.size() != 2 || wr_data_q[0] !== exp_data[0] || wr_data_q[1] !== exp_data[1]) begin
            fails++;
            $display("[TB] FAIL badchk_writes: count=%0d required 2 with model data", wr_addr_q.size());
        end
        tests++;
        if ({o_done, o_error, o_cpu_rst} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL badchk_status: done,error,cpu_rst=%b required 011",
                     {o_done, o_error, o_cpu_rst});
        end
        $display("[TB] bad checksum done");
    endtask

    task automatic test_oversize_empty();
        byte_q_t b;
        b = '{8'h01, 8'h01};
        model(b);
        run_frame(b, 1'b0);
        tests++;
        if ({o_error, o_done, o_busy, o_cpu_rst} !== {exp_error, exp_done, 2'b01}) begin
            fails++;
            $display("[TB] FAIL oversize_status: error,done,busy,cpu_rst=%b required %b",
                     {o_error, o_done, o_busy, o_cpu_rst}, {exp_error, exp_done, 2'b01});
        end
        tests++;
        if (wr_addr_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL oversize_writes: writes=%0d required 0", wr_addr_q.size());
        end
        b = '{8'h00, 8'h00, 8'h00};
        model(b);
        run_frame(b, 1'b0);
        tests++;
        if ({o_done, o_error, o_cpu_rst} !== {exp_done, exp_error, 1'b0} || wr_addr_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL empty: done,error,cpu_rst=%b writes=%0d required 100/0",
                     {o_done, o_error, o_cpu_rst}, wr_addr_q.size());
        end
        $display("[TB] oversize/empty done");
    endtask

    task automatic test_backpressure_restart();
        byte_q_t b;
        b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        model(b);
        run_frame(b, 1'b1);
        tests++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] !== exp_addr[0] || wr_data_q[0] !== exp_data[0] ||
            wr_addr_q[1] !== exp_addr[1] || wr_data_q[1] !== exp_data[1]) begin
            fails++;
            $display("[TB] FAIL bp_writes: count=%0d required 2 matching model", wr_addr_q.size());
        end
        tests++;
        if ({o_done, o_cpu_rst} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL bp_status: done,cpu_rst=%b required 10", {o_done, o_cpu_rst});
        end
        do_start();
        tests++;
        if ({o_cpu_rst, o_done, o_busy} !== 3'b101) begin
            fails++;
            $display("[TB] FAIL restart: cpu_rst,done,busy=%b required 101", {o_cpu_rst, o_done, o_busy});
        end
        $display("[TB] backpressure/restart done");
    endtask

    task automatic test_random();
        byte_q_t b;
        int n;
        logic [7:0] x;
        logic [7:0] r;
        for (int it = 0; it < 6; it++) begin
            b.delete();
            n = $urandom_range(0, 6);
            b.push_back(8'(n));
            b.push_back(8'h00);
            x = 8'(n);
            for (int k = 0; k < 4*n; k++) begin
                r = 8'($urandom);
                b.push_back(r);
                x = x ^ r;
            end
            if ($urandom_range(0, 1) == 1) b.push_back(x);
            else b.push_back(x ^ 8'($urandom_range(1, 255)));
            model(b);
            run_frame(b, 1'b1);
            tests++;
            if (wr_addr_q.size() != exp_addr.size()) begin
                fails++;
                $display("[TB] FAIL rand%0d_count: writes=%0d required %0d", it, wr_addr_q.size(), exp_addr.size());
            end else begin
                for (int j = 0; j < exp_addr.size(); j++) begin
                    tests++;
                    if (wr_addr_q[j] !== exp_addr[j] || wr_data_q[j] !== exp_data[j] ||
                        wr_cyc_q[j] != acc_cyc_q[2 + 4*j + 3]) begin
                        fails++;
                        $display("[TB] FAIL rand%0d_w%0d: %h/%h@%0d required %h/%h@%0d", it, j,
                                 wr_addr_q[j], wr_data_q[j], wr_cyc_q[j],
                                 exp_addr[j], exp_data[j], acc_cyc_q[2 + 4*j + 3]);
                    end
                end
            end
            tests++;
            if ({o_done, o_error, o_cpu_rst} !== {exp_done, exp_error, ~exp_done}) begin
                fails++;
                $display("[TB] FAIL rand%0d_status: done,error,cpu_rst=%b required %b", it,
                         {o_done, o_error, o_cpu_rst}, {exp_done, exp_error, ~exp_done});
            end
            $display("[TB] random frame %0d n=%0d done=%b", it, n, exp_done);
        end
    endtask

    task automatic test_reset_mid_load();
        byte_q_t b;
        b = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        clear_logs();
        do_start();
        for (int i = 0; i < 7; i++) send_byte(b[i], 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_rx_valid = 1'b0;
        @(posedge i_clk);
        #1;
        tests++;
        if ({o_busy, o_we, o_rx_ready, o_cpu_rst} !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL midrst_state: busy,we,ready,cpu_rst=%b required 0001",
                     {o_busy, o_we, o_rx_ready, o_cpu_rst});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_rx_valid = 1'b1;
        repeat (6) @(posedge i_clk);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        tests++;
        if (wr_addr_q.size() != 1 || o_busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_writes: writes=%0d busy=%b required 1/0", wr_addr_q.size(), o_busy);
        end
        $display("[TB] reset mid-load done");
    endtask

    task automatic test_full_size();
        byte_q_t b;
        int bad;
        b.delete();
        b.push_back(8'h00);
        b.push_back(8'h01);
        for (int i = 0; i < 256; i++) begin
            b.push_back(8'(i));
            b.push_back(8'h00);
            b.push_back(8'h00);
            b.push_back(8'h00);
        end
        b.push_back(8'h01);
        model(b);
        run_frame(b, 1'b0);
        tests++;
        if (wr_addr_q.size() != 256) begin
            fails++;
            $display("[TB] FAIL full_count: writes=%0d required 256", wr_addr_q.size());
        end else begin
            bad = 0;
            for (int j = 0; j < 256; j++) begin
                if (wr_addr_q[j] !== exp_addr[j] || wr_data_q[j] !== exp_data[j]) bad++;
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("[TB] FAIL full_words: %0d words differ from model, required 0", bad);
            end
            tests++;
            if (wr_addr_q[255] !== 10'h3FC || wr_data_q[255] !== 32'h000000FF) begin
                fails++;
                $display("[TB] FAIL full_last: %h/%h required 3fc/000000ff", wr_addr_q[255], wr_data_q[255]);
            end
        end
        tests++;
        if ({o_done, o_error, o_cpu_rst} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL full_status: done,error,cpu_rst=%b required 100", {o_done, o_error, o_cpu_rst});
        end
        $display("[TB] full size done");
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_oversize_empty();
        test_backpressure_restart();
        test_random();
        test_reset_mid_load();
        test_full_size();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
